// File: rtl/bank_timing_pkg.sv
// Shared types for the per-bank DRAM timing controller: bank state codes, command bit map,
// error codes and small elaboration helpers.
package bank_timing_pkg;

   typedef enum logic [4:0] {
      StIdle        = 5'h00,
      StActivating  = 5'h01,
      StActive      = 5'h03,
      StPrecharging = 5'h0a,
      StReading     = 5'h0b,
      StReadingAp   = 5'h0c,
      StRefreshing  = 5'h0d,
      StWriting     = 5'h12,
      StWritingAp   = 5'h13
   } bank_state_e;

   // Bit positions in the 19-bit command vector (ACT is the MSB).
   localparam int unsigned CmdWidth = 19;
   localparam int unsigned CmdAct  = 18, CmdBst = 17, CmdCfg = 16, CmdCkeh = 15, CmdCkel = 14;
   localparam int unsigned CmdDpd  = 13, CmdDpdx = 12, CmdMrr = 11, CmdMrw = 10, CmdPd = 9;
   localparam int unsigned CmdPdx  = 8, CmdPr = 7, CmdPra = 6, CmdRd = 5, CmdRda = 4;
   localparam int unsigned CmdRef  = 3, CmdSrf = 2, CmdWr = 1, CmdWra = 0;

   typedef enum logic [2:0] {
      ErrNone     = 3'd0,
      ErrMulti    = 3'd1,
      ErrActBusy  = 3'd2,
      ErrColState = 3'd3,
      ErrPrBusy   = 3'd4,
      ErrRefBusy  = 3'd5,
      ErrPraBusy  = 3'd6
   } err_code_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // States with a running timer that block PR and PRA.
   function automatic logic is_busy(input bank_state_e s);
      return s inside {StActivating, StReading, StReadingAp, StWriting, StWritingAp,
                       StRefreshing};
   endfunction

endpackage

// File: rtl/bank_timing_ctrl_bank_fsm.sv
// One bank's state register and down-counter. Strobes arrive pre-qualified as legal by the
// controller; a timed state of duration D loads D-1 and leaves when the counter reads zero.
module bank_fsm
   import bank_timing_pkg::*;
#(
   parameter int unsigned CntW = 6,
   parameter int unsigned TRcd = 17,
   parameter int unsigned TRd  = 21,
   parameter int unsigned TWr  = 30,
   parameter int unsigned TRp  = 17,
   parameter int unsigned TRfc = 34
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        act_i,
   input  logic        pr_i,
   input  logic        rd_i,
   input  logic        rda_i,
   input  logic        wr_i,
   input  logic        wra_i,
   input  logic        ref_all_i,
   input  logic        pra_all_i,
   output bank_state_e state_o,
   output logic        ready_o
);

   bank_state_e     state_q, state_d, exit_st;
   logic [CntW-1:0] cnt_q, cnt_d, exit_cnt;
   logic            timed;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      timed    = 1'b1;
      exit_st  = StIdle;
      exit_cnt = '0;
      case (state_q)
         StActivating, StReading, StWriting: exit_st = StActive;
         StReadingAp, StWritingAp: begin
            exit_st  = StPrecharging;
            exit_cnt = CntW'(TRp - 1);
         end
         StPrecharging, StRefreshing: exit_st = StIdle;
         default: timed = 1'b0;
      endcase

      state_d = state_q;
      cnt_d   = cnt_q;
      // A legal command overrides a coinciding timer expiry.
      if (ref_all_i) begin
         state_d = StRefreshing;
         cnt_d   = CntW'(TRfc - 1);
      end else if (act_i) begin
         state_d = StActivating;
         cnt_d   = CntW'(TRcd - 1);
      end else if (rd_i) begin
         state_d = StReading;
         cnt_d   = CntW'(TRd - 1);
      end else if (rda_i) begin
         state_d = StReadingAp;
         cnt_d   = CntW'(TRd - 1);
      end else if (wr_i) begin
         state_d = StWriting;
         cnt_d   = CntW'(TWr - 1);
      end else if (wra_i) begin
         state_d = StWritingAp;
         cnt_d   = CntW'(TWr - 1);
      end else if ((pr_i || pra_all_i) && state_q == StActive) begin
         state_d = StPrecharging;
         cnt_d   = CntW'(TRp - 1);
      end else if (timed) begin
         if (cnt_q == '0) begin
            state_d = exit_st;
            cnt_d   = exit_cnt;
         end else begin
            cnt_d = cnt_q - CntW'(1);
         end
      end
   end

   always_comb begin
      state_o = state_q;
      ready_o = (state_q == StIdle) || (state_q == StActive);
   end

endmodule

// File: rtl/bank_timing_ctrl.sv
// Per-bank DRAM timing controller: decodes the target bank, judges each command's legality
// against current bank states, drives per-bank strobes and reports rejected commands.
module bank_timing_ctrl
   import bank_timing_pkg::*;
#(
   parameter int unsigned BGWIDTH = 2,
   parameter int unsigned BAWIDTH = 2,
   parameter int unsigned BL      = 8,
   parameter int unsigned T_RCD   = 17,
   parameter int unsigned T_CL    = 17,
   parameter int unsigned T_CWL   = 12,
   parameter int unsigned T_WR    = 14,
   parameter int unsigned T_RP    = 17,
   parameter int unsigned T_RFC   = 34
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic [(BGWIDTH > 0 ? BGWIDTH : 1)-1:0]            bg,
   input  logic [BAWIDTH-1:0]                               ba,
   input  logic [18:0]                                      commands,
   output logic [(1 << BGWIDTH)-1:0][(1 << BAWIDTH)-1:0][4:0] BankFSM,
   output logic [(1 << (BGWIDTH + BAWIDTH))-1:0]             bank_ready,
   output logic                                             all_idle,
   output logic                                             cmd_err,
   output logic [2:0]                                       err_code
);

   localparam int unsigned NGroups   = 1 << BGWIDTH;
   localparam int unsigned NPerGroup = 1 << BAWIDTH;
   localparam int unsigned NBanks    = NGroups * NPerGroup;
   localparam int unsigned IdxW      = BGWIDTH + BAWIDTH;
   localparam int unsigned RdDur     = T_CL + BL / 2;
   localparam int unsigned WrDur     = T_CWL + BL / 2 + T_WR;
   localparam int unsigned MaxDur    = max_u(max_u(max_u(T_RCD, RdDur), max_u(WrDur, T_RP)),
                                             T_RFC);
   localparam int unsigned CntW      = $clog2(MaxDur + 1);

   bank_state_e       st [NBanks];
   logic [NBanks-1:0] ready_w, sel_oh;
   logic [NBanks-1:0] act_s, pr_s, rd_s, rda_s, wr_s, wra_s;
   logic [IdxW-1:0]   sel;
   logic [7:0]        main_cmds;
   logic              c_act, c_pr, c_pra, c_rd, c_rda, c_ref, c_wr, c_wra;
   logic              all_idle_c, any_busy, legal, cmd_err_q;
   bank_state_e       tgt;
   err_code_e         err_d, err_code_q;

   if (BGWIDTH > 0) begin : g_sel_bg
      assign sel = {bg, ba};
   end else begin : g_sel_nobg
      assign sel = ba;
   end

   assign c_act = commands[CmdAct];
   assign c_pr  = commands[CmdPr];
   assign c_pra = commands[CmdPra];
   assign c_rd  = commands[CmdRd];
   assign c_rda = commands[CmdRda];
   assign c_ref = commands[CmdRef];
   assign c_wr  = commands[CmdWr];
   assign c_wra = commands[CmdWra];
   assign main_cmds = {c_act, c_pr, c_pra, c_rd, c_rda, c_ref, c_wr, c_wra};

   always_comb begin
      all_idle_c = 1'b1;
      any_busy   = 1'b0;
      for (int i = 0; i < int'(NBanks); i++) begin
         if (st[i] != StIdle) all_idle_c = 1'b0;
         if (is_busy(st[i])) any_busy = 1'b1;
      end
   end

   // Legality is always judged on the registered (pre-expiry) state.
   always_comb begin
      tgt   = st[sel];
      err_d = ErrNone;
      if ($countones(main_cmds) > 1) begin
         err_d = ErrMulti;
      end else if (c_act && tgt != StIdle) begin
         err_d = ErrActBusy;
      end else if ((c_rd || c_rda || c_wr || c_wra) &&
                   !(tgt inside {StActive, StReading, StWriting})) begin
         err_d = ErrColState;
      end else if (c_pr && is_busy(tgt)) begin
         err_d = ErrPrBusy;
      end else if (c_ref && !all_idle_c) begin
         err_d = ErrRefBusy;
      end else if (c_pra && any_busy) begin
         err_d = ErrPraBusy;
      end
   end

   always_comb begin
      sel_oh      = '0;
      sel_oh[sel] = 1'b1;
   end

   assign legal = (err_d == ErrNone);
   assign act_s = sel_oh & {NBanks{legal & c_act}};
   assign pr_s  = sel_oh & {NBanks{legal & c_pr}};
   assign rd_s  = sel_oh & {NBanks{legal & c_rd}};
   assign rda_s = sel_oh & {NBanks{legal & c_rda}};
   assign wr_s  = sel_oh & {NBanks{legal & c_wr}};
   assign wra_s = sel_oh & {NBanks{legal & c_wra}};

   for (genvar i = 0; i < NBanks; i++) begin : g_bank
      bank_fsm #(
         .CntW (CntW),
         .TRcd (T_RCD),
         .TRd  (RdDur),
         .TWr  (WrDur),
         .TRp  (T_RP),
         .TRfc (T_RFC)
      ) u_bank (
         .clk_i     (clk),
         .reset_i   (reset),
         .act_i     (act_s[i]),
         .pr_i      (pr_s[i]),
         .rd_i      (rd_s[i]),
         .rda_i     (rda_s[i]),
         .wr_i      (wr_s[i]),
         .wra_i     (wra_s[i]),
         .ref_all_i (legal & c_ref),
         .pra_all_i (legal & c_pra),
         .state_o   (st[i]),
         .ready_o   (ready_w[i])
      );
   end

   for (genvar g = 0; g < NGroups; g++) begin : g_grp
      for (genvar b = 0; b < NPerGroup; b++) begin : g_ba
         assign BankFSM[g][b] = st[g * NPerGroup + b];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_err_q  <= 1'b0;
         err_code_q <= ErrNone;
      end else begin
         cmd_err_q <= !legal;
         if (!legal) err_code_q <= err_d;
      end
   end

   assign bank_ready = ready_w;
   assign all_idle   = all_idle_c;
   assign cmd_err    = cmd_err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_bank_timing_ctrl.sv
// Randomized bench for bank_timing_ctrl: a timestamp-based per-bank reference model predicts
// every bank state, ready flags and error reporting after each clock edge.
module tb_bank_timing_ctrl;

   localparam int NBanks = 16;
   localparam int DRcd = 17, DRd = 21, DWr = 30, DRp = 17, DRfc = 34;
   localparam logic [4:0] SIdle = 5'h00, SActivating = 5'h01, SActive = 5'h03;
   localparam logic [4:0] SPrecharging = 5'h0a, SReading = 5'h0b, SReadingAp = 5'h0c;
   localparam logic [4:0] SRefreshing = 5'h0d, SWriting = 5'h12, SWritingAp = 5'h13;
   localparam int BitAct = 18, BitPr = 7, BitPra = 6, BitRd = 5, BitRda = 4;
   localparam int BitRef = 3, BitWr = 1, BitWra = 0;
   localparam logic [18:0] IgnMask = 19'b0_1111111111_00000_1_00;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [1:0]            bg = '0, ba = '0;
   logic [18:0]           commands = '0;
   logic [3:0][3:0][4:0]  BankFSM;
   logic [15:0]           bank_ready;
   logic                  all_idle, cmd_err;
   logic [2:0]            err_code;

   logic [4:0] m_st [NBanks];
   int         m_end [NBanks];
   int         now = 0;
   logic       m_err;
   logic [2:0] m_code;
   int         checks = 0, failures = 0;

   bank_timing_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .bg         (bg),
      .ba         (ba),
      .commands   (commands),
      .BankFSM    (BankFSM),
      .bank_ready (bank_ready),
      .all_idle   (all_idle),
      .cmd_err    (cmd_err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, now, got, exp);
      end
   endtask

   function automatic logic [18:0] mk(input int b);
      logic [18:0] v;
      v = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic busy(input logic [4:0] s);
      return s inside {SActivating, SReading, SReadingAp, SWriting, SWritingAp, SRefreshing};
   endfunction

   task automatic set_bank(input int i, input logic [4:0] s, input int dur);
      m_st[i]  = s;
      m_end[i] = now + dur;
   endtask

   // Model of one clock edge: judge on pre-edge states, expire timers, then apply the command.
   task automatic model_edge(input logic rst, input logic [18:0] c, input int t);
      logic [4:0] pre [NBanks];
      logic       all_idle_m, busy_any;
      logic [2:0] code;
      int         n;
      if (rst) begin
         for (int i = 0; i < NBanks; i++) set_bank(i, SIdle, 0);
         m_err = 1'b0;
         m_code = 3'd0;
         return;
      end
      all_idle_m = 1'b1;
      busy_any = 1'b0;
      for (int i = 0; i < NBanks; i++) begin
         pre[i] = m_st[i];
         if (m_st[i] != SIdle) all_idle_m = 1'b0;
         if (busy(m_st[i])) busy_any = 1'b1;
      end
      n = int'(c[BitAct]) + int'(c[BitPr]) + int'(c[BitPra]) + int'(c[BitRd]) +
          int'(c[BitRda]) + int'(c[BitRef]) + int'(c[BitWr]) + int'(c[BitWra]);
      code = 3'd0;
      if (n > 1) code = 3'd1;
      else if (c[BitAct] && pre[t] != SIdle) code = 3'd2;
      else if ((c[BitRd] || c[BitRda] || c[BitWr] || c[BitWra]) &&
               !(pre[t] inside {SActive, SReading, SWriting})) code = 3'd3;
      else if (c[BitPr] && busy(pre[t])) code = 3'd4;
      else if (c[BitRef] && !all_idle_m) code = 3'd5;
      else if (c[BitPra] && busy_any) code = 3'd6;

      for (int i = 0; i < NBanks; i++) begin
         if (busy(m_st[i]) || m_st[i] == SPrecharging) begin
            if (m_end[i] == now) begin
               case (m_st[i])
                  SReadingAp, SWritingAp:  set_bank(i, SPrecharging, DRp);
                  SPrecharging, SRefreshing: m_st[i] = SIdle;
                  default:                 m_st[i] = SActive;
               endcase
            end
         end
      end

      if (code == 3'd0) begin
         if (c[BitAct]) set_bank(t, SActivating, DRcd);
         if (c[BitRd])  set_bank(t, SReading, DRd);
         if (c[BitRda]) set_bank(t, SReadingAp, DRd);
         if (c[BitWr])  set_bank(t, SWriting, DWr);
         if (c[BitWra]) set_bank(t, SWritingAp, DWr);
         if (c[BitPr] && pre[t] == SActive) set_bank(t, SPrecharging, DRp);
         for (int i = 0; i < NBanks; i++) begin
            if (c[BitRef]) set_bank(i, SRefreshing, DRfc);
            if (c[BitPra] && pre[i] == SActive) set_bank(i, SPrecharging, DRp);
         end
      end
      m_err = (code != 3'd0);
      if (code != 3'd0) m_code = code;
   endtask

   task automatic compare_all();
      logic [79:0] ef;
      logic [15:0] er;
      logic        ea;
      ea = 1'b1;
      for (int i = 0; i < NBanks; i++) begin
         ef[i*5 +: 5] = m_st[i];
         er[i] = (m_st[i] == SIdle) || (m_st[i] == SActive);
         if (m_st[i] != SIdle) ea = 1'b0;
      end
      check_eq("bank_states", BankFSM, ef);
      check_eq("bank_ready", bank_ready, er);
      check_eq("all_idle", all_idle, ea);
      check_eq("cmd_err", cmd_err, m_err);
      check_eq("err_code", err_code, m_code);
   endtask

   task automatic step(input logic rst, input logic [18:0] c, input int t);
      logic [3:0] tb;
      tb = 4'(t);
      reset = rst;
      commands = c;
      bg = tb[3:2];
      ba = tb[1:0];
      @(posedge clk);
      model_edge(rst, c, t);
      now++;
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, '0, 0);
   endtask

   function automatic int main_bit(input int k);
      case (k)
         0: return BitAct;
         1: return BitPr;
         2: return BitPra;
         3: return BitRd;
         4: return BitRda;
         5: return BitRef;
         6: return BitWr;
         default: return BitWra;
      endcase
   endfunction

   initial begin
      int          r, t, k1, off;
      logic [18:0] c;
      step(1'b1, '0, 0);
      step(1'b1, '0, 0);
      step(1'b0, mk(BitAct), 5);  idle(20);
      step(1'b0, mk(BitWr), 5);   idle(9);
      step(1'b0, mk(BitRd), 5);   idle(25);
      step(1'b0, mk(BitWra), 5);  idle(50);
      step(1'b0, mk(BitAct), 5);  idle(20);
      step(1'b0, mk(BitRda), 5);  idle(40);
      step(1'b0, mk(BitRef), 0);  idle(36);
      step(1'b0, mk(BitAct), 5);  idle(20);
      step(1'b0, mk(BitRef), 0);
      step(1'b0, mk(BitAct), 5);
      step(1'b0, mk(BitRd) | mk(BitWr), 5);
      step(1'b0, mk(BitPr), 5);   idle(20);
      step(1'b0, mk(BitAct), 0);
      step(1'b0, mk(BitAct), 11);
      step(1'b0, mk(BitPr), 0);
      step(1'b0, mk(BitPra), 0);
      step(1'b0, mk(BitRd), 3);   idle(20);
      step(1'b0, mk(BitPra), 0);  idle(20);
      // Column command on the very edge ACTIVATING expires: still judged as ACTIVATING.
      step(1'b0, mk(BitAct), 7);  idle(16);
      step(1'b0, mk(BitRd), 7);   idle(3);
      step(1'b0, mk(BitRd), 7);   idle(25);
      step(1'b0, mk(BitPr), 7);   idle(20);
      step(1'b0, IgnMask, 4);
      step(1'b0, IgnMask | mk(BitAct), 4); idle(20);
      step(1'b0, mk(BitPra), 0);  idle(18);
      step(1'b0, mk(BitRef), 0);  idle(5);
      step(1'b1, '0, 0);          idle(2);

      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 999);
         t = $urandom_range(0, 15);
         c = ($urandom_range(0, 1) != 0) ? (IgnMask & 19'($urandom)) : '0;
         if (r < 4) begin
            step(1'b1, c, t);
            continue;
         end else if (r < 300) begin
            c = c;
         end else if (r < 450) begin
            c |= mk(BitAct);
         end else if (r < 620) begin
            c |= mk(main_bit($urandom_range(3, 4)) - 0);
            if ($urandom_range(0, 1) != 0) c = (c & IgnMask) | mk(($urandom_range(0, 1) != 0) ?
                                                                 BitWr : BitWra);
            if ($urandom_range(0, 3) != 0) begin
               off = $urandom_range(0, 15);
               for (int i = 0; i < NBanks; i++) begin
                  if (m_st[(i + off) % NBanks] inside {SActive, SReading, SWriting}) begin
                     t = (i + off) % NBanks;
                     break;
                  end
               end
            end
         end else if (r < 720) begin
            c |= mk(BitPr);
         end else if (r < 770) begin
            c |= mk(BitPra);
         end else if (r < 800) begin
            c |= mk(BitRef);
         end else if (r < 850) begin
            k1 = $urandom_range(0, 7);
            c |= mk(main_bit(k1)) | mk(main_bit((k1 + 1 + $urandom_range(0, 6)) % 8));
         end
         step(1'b0, c, t);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
